hazard_unit_md: RTL and testbench

- Parametrised successor to the 5-stage pipeline hazard unit. Covers the same ground: E-stage and D-stage forwarding selects, load-use/branch/jr stalls, and jal link forwarding.
- Adds a sequential scoreboard for the multi-cycle mult/div unit (HI/LO busy countdown) and a saturating stall-cycle performance counter.
- Sits beside the datapath. Drives the F/D enables, the E flush and the forwarding muxes.

---
 rtl/hazard_unit_md_pkg.sv | 17 +
 rtl/hazard_unit_md_md_scoreboard.sv | 39 +++
 rtl/hazard_unit_md.sv | 123 ++++++++++++
 tb/tb_hazard_unit_md.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_md_pkg.sv
// Shared encodings and defaults for the hazard unit and the datapath forwarding muxes.
// No logic of its own.
package hazard_unit_md_pkg;

  localparam int REG_AW_DEF   = 5;
  localparam int LINK_REG_DEF = 31;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Countdown must be able to hold the longer of the two latencies.
  function automatic int md_cnt_w(input int mult_lat, input int div_lat);
    return $clog2(((mult_lat > div_lat) ? mult_lat : div_lat) + 1);
  endfunction

endpackage

// File: rtl/hazard_unit_md_md_scoreboard.sv
// HI/LO busy scoreboard: a start loads the unit latency, then the count drains by one per cycle.
// Busy rises the cycle after a start; a newer start always reloads.
module md_scoreboard
  import hazard_unit_md_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 32,
  parameter int MD_W     = md_cnt_w(MULT_LAT, DIV_LAT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start,
  input  logic md_is_div,
  output logic md_busy
);

  logic [MD_W-1:0] md_cnt_q;
  logic [MD_W-1:0] md_cnt_d;

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start) begin
      md_cnt_d = md_is_div ? MD_W'(DIV_LAT) : MD_W'(MULT_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign md_busy = (md_cnt_q != '0);

endmodule

// File: rtl/hazard_unit_md.sv
// Pipeline hazard unit: E/D forwarding selects, load-use/branch/jr/mult-div stalls, stall counter.
// Selects and stalls are combinational; only the mult/div scoreboard and StallCount hold state.
module hazard_unit_md
  import hazard_unit_md_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int LINK_REG = LINK_REG_DEF,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 32,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs_D,
  input  logic [REG_AW-1:0] Rt_D,
  input  logic [REG_AW-1:0] Rs_E,
  input  logic [REG_AW-1:0] Rt_E,
  input  logic [REG_AW-1:0] WriteReg_E,
  input  logic [REG_AW-1:0] WriteReg_M,
  input  logic [REG_AW-1:0] WriteReg_W,
  input  logic              RegWrite_E,
  input  logic              RegWrite_M,
  input  logic              RegWrite_W,
  input  logic              MemRead_E,
  input  logic              MemRead_M,
  input  logic              BranchD,
  input  logic              JrD,
  input  logic              JalM,
  input  logic              MdStart_E,
  input  logic              MdIsDiv_E,
  input  logic              MdUse_D,
  input  logic              StallCntClr,
  output logic [1:0]        ForwardA_E,
  output logic [1:0]        ForwardB_E,
  output logic [1:0]        ForwardA_D,
  output logic [1:0]        ForwardB_D,
  output logic              ForwardJal,
  output logic              Stall_F,
  output logic              Stall_D,
  output logic              Flush_E,
  output logic              MdBusy,
  output logic [CNT_W-1:0]  StallCount
);

  localparam logic [REG_AW-1:0] LINK = REG_AW'(LINK_REG);

  logic             lw_stall;
  logic             br_stall;
  logic             jr_stall;
  logic             md_stall;
  logic             stall;
  logic             hit_e_rs;
  logic             hit_e_rt;
  logic             hit_m_rs;
  logic             hit_m_rt;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  md_scoreboard #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .md_start  (MdStart_E),
    .md_is_div (MdIsDiv_E),
    .md_busy   (MdBusy)
  );

  always_comb begin
    ForwardA_E = FWD_RF;
    if (Rs_E != '0 && Rs_E == WriteReg_M && RegWrite_M)      ForwardA_E = FWD_M;
    else if (Rs_E != '0 && Rs_E == WriteReg_W && RegWrite_W) ForwardA_E = FWD_W;

    ForwardB_E = FWD_RF;
    if (Rt_E != '0 && Rt_E == WriteReg_M && RegWrite_M)      ForwardB_E = FWD_M;
    else if (Rt_E != '0 && Rt_E == WriteReg_W && RegWrite_W) ForwardB_E = FWD_W;

    // A load in M has no ALU result yet, so it never feeds D directly.
    ForwardA_D[0] = (Rs_D != '0) && (Rs_D == WriteReg_M) && RegWrite_M && !MemRead_M;
    ForwardB_D[0] = (Rt_D != '0) && (Rt_D == WriteReg_M) && RegWrite_M && !MemRead_M;
    ForwardA_D[1] = BranchD && (Rs_D == LINK) && JalM;
    ForwardB_D[1] = BranchD && (Rt_D == LINK) && JalM;
    ForwardJal    = JrD && JalM && (Rs_D == LINK);
  end

  always_comb begin
    hit_e_rs = RegWrite_E && (WriteReg_E != '0) && (WriteReg_E == Rs_D);
    hit_e_rt = RegWrite_E && (WriteReg_E != '0) && (WriteReg_E == Rt_D);
    hit_m_rs = MemRead_M && (WriteReg_M != '0) && (WriteReg_M == Rs_D);
    hit_m_rt = MemRead_M && (WriteReg_M != '0) && (WriteReg_M == Rt_D);

    lw_stall = MemRead_E && (Rt_E != '0) && ((Rs_D == Rt_E) || (Rt_D == Rt_E));
    br_stall = BranchD && (hit_e_rs || hit_e_rt || hit_m_rs || hit_m_rt);
    jr_stall = JrD && (hit_e_rs || hit_m_rs);
    md_stall = MdUse_D && (MdBusy || MdStart_E);
    stall    = lw_stall || br_stall || jr_stall || md_stall;

    Stall_F = stall;
    Stall_D = stall;
    Flush_E = stall;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StallCntClr) begin
      stall_cnt_d = '0;
    end else if (stall && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit_md.sv
// Bench for hazard_unit_md: combinational vector table through an expect queue, then
// hand-written multi-cycle sequences for the mult/div scoreboard, stall counter and reset.
module tb_hazard_unit_md;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
  logic       RegWrite_E, RegWrite_M, RegWrite_W, MemRead_E, MemRead_M;
  logic       BranchD, JrD, JalM, MdStart_E, MdIsDiv_E, MdUse_D, StallCntClr;
  logic [1:0] ForwardA_E, ForwardB_E, ForwardA_D, ForwardB_D;
  logic       ForwardJal, Stall_F, Stall_D, Flush_E, MdBusy;
  logic [3:0] StallCount;

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
    logic       rw_e, rw_m, rw_w, mr_e, mr_m, br, jr, jalm;
    logic [1:0] fa_e, fb_e, fa_d, fb_d;
    logic       fjal, stall;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];
  vec_t exp_q[$];

  hazard_unit_md #(
    .MULT_LAT (5),
    .DIV_LAT  (32),
    .CNT_W    (4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs_D(Rs_D), .Rt_D(Rt_D), .Rs_E(Rs_E), .Rt_E(Rt_E),
    .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
    .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .MemRead_E(MemRead_E), .MemRead_M(MemRead_M),
    .BranchD(BranchD), .JrD(JrD), .JalM(JalM),
    .MdStart_E(MdStart_E), .MdIsDiv_E(MdIsDiv_E), .MdUse_D(MdUse_D),
    .StallCntClr(StallCntClr),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .ForwardA_D(ForwardA_D), .ForwardB_D(ForwardB_D),
    .ForwardJal(ForwardJal), .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_E(Flush_E),
    .MdBusy(MdBusy), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input int rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w,
                              input int rw_e, rw_m, rw_w, mr_e, mr_m, br, jr, jalm,
                              input int fa_e, fb_e, fa_d, fb_d, fjal, stall);
    vec_t v;
    v.rs_d = 5'(rs_d); v.rt_d = 5'(rt_d); v.rs_e = 5'(rs_e); v.rt_e = 5'(rt_e);
    v.wr_e = 5'(wr_e); v.wr_m = 5'(wr_m); v.wr_w = 5'(wr_w);
    v.rw_e = 1'(rw_e); v.rw_m = 1'(rw_m); v.rw_w = 1'(rw_w);
    v.mr_e = 1'(mr_e); v.mr_m = 1'(mr_m);
    v.br = 1'(br); v.jr = 1'(jr); v.jalm = 1'(jalm);
    v.fa_e = 2'(fa_e); v.fb_e = 2'(fb_e); v.fa_d = 2'(fa_d); v.fb_d = 2'(fb_d);
    v.fjal = 1'(fjal); v.stall = 1'(stall);
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Rs_D = '0; Rt_D = '0; Rs_E = '0; Rt_E = '0;
    WriteReg_E = '0; WriteReg_M = '0; WriteReg_W = '0;
    RegWrite_E = 0; RegWrite_M = 0; RegWrite_W = 0; MemRead_E = 0; MemRead_M = 0;
    BranchD = 0; JrD = 0; JalM = 0; MdStart_E = 0; MdIsDiv_E = 0; MdUse_D = 0;
    StallCntClr = 0;
  endtask

  task automatic apply(input vec_t v);
    Rs_D = v.rs_d; Rt_D = v.rt_d; Rs_E = v.rs_e; Rt_E = v.rt_e;
    WriteReg_E = v.wr_e; WriteReg_M = v.wr_m; WriteReg_W = v.wr_w;
    RegWrite_E = v.rw_e; RegWrite_M = v.rw_m; RegWrite_W = v.rw_w;
    MemRead_E = v.mr_e; MemRead_M = v.mr_m;
    BranchD = v.br; JrD = v.jr; JalM = v.jalm;
  endtask

  // Load-use hazard pattern used to hold a stall for several cycles.
  task automatic lw_hazard();
    MemRead_E = 1; Rt_E = 5'd8; Rs_D = 5'd8;
  endtask

  initial begin
    vec_t e;
    //           rsd rtd rse rte wre wrm wrw  rwe rwm rww mre mrm br jr jal  fae fbe fad fbd fj st
    vecs[0]  = mk( 0,  0,  3,  0,  0,  3,  3,  0,  1,  1,  0,  0, 0, 0, 0,  2,  0,  0,  0, 0, 0);
    vecs[1]  = mk( 0,  0,  0,  0,  0,  3,  3,  0,  1,  1,  0,  0, 0, 0, 0,  0,  0,  0,  0, 0, 0);
    vecs[2]  = mk( 0,  0,  4,  5,  0,  4,  4,  0,  0,  1,  0,  0, 0, 0, 0,  1,  0,  0,  0, 0, 0);
    vecs[3]  = mk( 0,  0,  7,  7,  0,  7,  7,  0,  1,  1,  0,  0, 0, 0, 0,  2,  2,  0,  0, 0, 0);
    vecs[4]  = mk( 8,  0,  0,  8,  0,  0,  0,  0,  0,  0,  1,  0, 0, 0, 0,  0,  0,  0,  0, 0, 1);
    vecs[5]  = mk( 8,  0,  0,  0,  0,  0,  0,  0,  0,  0,  1,  0, 0, 0, 0,  0,  0,  0,  0, 0, 0);
    vecs[6]  = mk( 9,  0,  0,  0,  0,  9,  0,  0,  1,  0,  0,  0, 0, 0, 0,  0,  0,  1,  0, 0, 0);
    vecs[7]  = mk( 9,  0,  0,  0,  0,  9,  0,  0,  1,  0,  0,  1, 0, 0, 0,  0,  0,  0,  0, 0, 0);
    vecs[8]  = mk(31,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 1, 0, 1,  0,  0,  2,  0, 0, 0);
    vecs[9]  = mk(31,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 1, 1,  0,  0,  0,  0, 1, 0);
    vecs[10] = mk( 5,  6,  0,  0,  6,  0,  0,  1,  0,  0,  0,  0, 1, 0, 0,  0,  0,  0,  0, 0, 1);
    vecs[11] = mk( 5,  0,  0,  0,  0,  5,  0,  0,  1,  0,  0,  1, 1, 0, 0,  0,  0,  0,  0, 0, 1);
    vecs[12] = mk( 0,  0,  0,  0,  0,  0,  0,  1,  0,  0,  0,  0, 1, 0, 0,  0,  0,  0,  0, 0, 0);
    vecs[13] = mk(12,  0,  0,  0, 12,  0,  0,  1,  0,  0,  0,  0, 0, 1, 0,  0,  0,  0,  0, 0, 1);
    vecs[14] = mk( 3, 12,  0,  0, 12,  0,  0,  1,  0,  0,  0,  0, 0, 1, 0,  0,  0,  0,  0, 0, 0);
    vecs[15] = mk( 0, 31,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 1, 0, 1,  0,  0,  0,  2, 0, 0);

    idle();
    rst_n = 0;
    tick(); tick();
    #1;
    chk("rst_busy", 32'(MdBusy), 0);
    chk("rst_cnt", 32'(StallCount), 0);
    chk("rst_stall", 32'(Stall_D), 0);
    rst_n = 1;

    // Combinational table; counter held clear so it cannot disturb later sequences.
    StallCntClr = 1;
    for (int i = 0; i < NV; i++) begin
      tick();
      apply(vecs[i]);
      exp_q.push_back(vecs[i]);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("v%0d_fa_e", i), 32'(ForwardA_E), 32'(e.fa_e));
      chk($sformatf("v%0d_fb_e", i), 32'(ForwardB_E), 32'(e.fb_e));
      chk($sformatf("v%0d_fa_d", i), 32'(ForwardA_D), 32'(e.fa_d));
      chk($sformatf("v%0d_fb_d", i), 32'(ForwardB_D), 32'(e.fb_d));
      chk($sformatf("v%0d_fjal", i), 32'(ForwardJal), 32'(e.fjal));
      chk($sformatf("v%0d_stf", i), 32'(Stall_F), 32'(e.stall));
      chk($sformatf("v%0d_std", i), 32'(Stall_D), 32'(e.stall));
      chk($sformatf("v%0d_fle", i), 32'(Flush_E), 32'(e.stall));
    end
    tick();
    idle();
    StallCntClr = 1;
    tick();
    StallCntClr = 0;

    // mult started in cycle 0 with a dependent op held in D.
    MdStart_E = 1; MdIsDiv_E = 0; MdUse_D = 1;
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) begin
        tick();
        MdStart_E = 0;
      end
      #1;
      chk($sformatf("mul_busy_c%0d", k), 32'(MdBusy), int'(k >= 1 && k <= 5));
      chk($sformatf("mul_stall_c%0d", k), 32'(Stall_D), int'(k <= 5));
      chk($sformatf("mul_cnt_c%0d", k), 32'(StallCount), (k <= 6) ? k : 6);
    end
    idle();

    // div at cycle 0, mult at cycle 3: the mult reload shortens the busy window.
    tick();
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) tick();
      MdStart_E = (k == 0 || k == 3);
      MdIsDiv_E = (k == 0);
      #1;
      chk($sformatf("reload_busy_c%0d", k), 32'(MdBusy), int'(k >= 1 && k <= 8));
    end
    idle();

    // Lone div: busy for exactly DIV_LAT cycles.
    tick();
    for (int k = 0; k <= 34; k++) begin
      if (k > 0) tick();
      MdStart_E = (k == 0);
      MdIsDiv_E = 1;
      #1;
      chk($sformatf("div_busy_c%0d", k), 32'(MdBusy), int'(k >= 1 && k <= 32));
    end
    idle();

    // Saturation at 15 with a held stall, then clear wins over an active stall.
    StallCntClr = 1;
    tick();
    StallCntClr = 0;
    lw_hazard();
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) tick();
      #1;
      chk($sformatf("sat_cnt_c%0d", k), 32'(StallCount), (k < 15) ? k : 15);
    end
    tick();
    StallCntClr = 1;
    #1;
    chk("clr_same_cycle", 32'(StallCount), 15);
    tick();
    StallCntClr = 0;
    #1;
    chk("clr_next_cycle", 32'(StallCount), 0);
    tick();
    #1;
    chk("clr_then_count", 32'(StallCount), 1);
    idle();

    // Reset in the middle of a div, with a new start and a stall on the same edge.
    tick();
    MdStart_E = 1; MdIsDiv_E = 1;
    tick();
    MdStart_E = 0;
    repeat (4) tick();
    rst_n = 0;
    MdStart_E = 1; MdIsDiv_E = 1;
    lw_hazard();
    #1;
    chk("rstmid_busy_before", 32'(MdBusy), 1);
    chk("rstmid_stall_comb", 32'(Stall_D), 1);
    tick();
    #1;
    chk("rstmid_busy_after", 32'(MdBusy), 0);
    chk("rstmid_cnt_after", 32'(StallCount), 0);
    chk("rstmid_fwd_comb", 32'(Flush_E), 1);
    rst_n = 1;
    idle();
    tick();
    #1;
    chk("rstmid_idle_busy", 32'(MdBusy), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
